// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the line memory controller.
// Contents: FSM state encoding, requester-kind encoding, byte width,
// and an index-width helper. The helper keeps single-entry vectors at 1 bit.
package mem_ctrl_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    IOWR
  } state_t;

  typedef enum logic [1:0] {
    LINE_RD,
    LINE_WR,
    IO_RD,
    IO_WR
  } req_kind_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_mem_ctrler_if.sv
// Client-side bundle of the line memory controller: the line clients and the IO channel.
//   master : driven by the cache clients / IO unit (valid, rw, addr, wdata)
//   slave  : driven by the controller (ready pulses, read data)
// line_addr and line_wdata are flattened per port.
// Byte k of port p is line_wdata[(p*LINE_BYTES+k)*8 +: 8].
interface line_mem_ctrler_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINE_PORTS = 2,
  parameter int unsigned LINE_BYTES     = 16,
  parameter int unsigned ADDR_WIDTH     = 32
);

  logic [NUM_LINE_PORTS-1:0]                       line_valid;
  logic [NUM_LINE_PORTS-1:0]                       line_rw;
  logic [NUM_LINE_PORTS*ADDR_WIDTH-1:0]            line_addr;
  logic [NUM_LINE_PORTS*LINE_BYTES*BYTE_WIDTH-1:0] line_wdata;
  logic [NUM_LINE_PORTS-1:0]                       line_ready;
  logic [LINE_BYTES*BYTE_WIDTH-1:0]                line_rdata;

  logic                  io_valid;
  logic                  io_rw;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [BYTE_WIDTH-1:0] io_wdata;
  logic                  io_ready;
  logic [BYTE_WIDTH-1:0] io_rdata;

  modport master (
    output line_valid, line_rw, line_addr, line_wdata,
    output io_valid, io_rw, io_addr, io_wdata,
    input  line_ready, line_rdata, io_ready, io_rdata
  );

  modport slave (
    input  line_valid, line_rw, line_addr, line_wdata,
    input  io_valid, io_rw, io_addr, io_wdata,
    output line_ready, line_rdata, io_ready, io_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters.
//   clk, rst_n   : clock, async active-low reset
//   en           : global enable; pointer holds when low
//   req          : request vector
//   advance      : commit the current grant (pointer moves to grant_idx)
//   grant_onehot : combinational one-hot grant, zero when no request
//   grant_idx    : index of the granted requester
// The search starts at the entry after the last committed grant.
// Reset points at N-1, so entry 0 wins first.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N-1:0]           req,
  input  logic                   advance,
  output logic [N-1:0]           grant_onehot,
  output logic [idx_bits(N)-1:0] grant_idx
);

  localparam int unsigned IW = idx_bits(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Walk from the farthest offset down to the nearest.
  // The closest requesting entry after the pointer then overrides the others.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = '0;
    for (int unsigned off = N; off >= 1; off--) begin
      cand = IW'((int'(ptr_q) + off) % N);
      if (req[cand]) begin
        grant_onehot       = '0;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N - 1);
    end else if (en && advance) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/line_mem_ctrler.sv
// Line memory controller: serialises line fills, line write-backs and single-byte IO accesses onto a byte-wide RAM port.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   rdy             : global enable, all registers hold when low
//   io_buffer_full  : IO write sink cannot take a byte
//   ram_din         : RAM read data (RAM_RD_LAT edges after address)
//   ram_rw/addr/dout: RAM command (rw=1 write)
//   bus             : client bundle (line ports + IO channel)
// Arbitration: the IO channel has strict priority; the line ports are served round-robin.
// A stalled IO write blocks the line ports so that ordering is preserved.
module line_mem_ctrler
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LINE_PORTS = 2,
  parameter int unsigned LINE_BYTES     = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  io_buffer_full,
  input  logic [BYTE_WIDTH-1:0] ram_din,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTE_WIDTH-1:0] ram_dout,
  line_mem_ctrler_if.slave      bus
);

  localparam int unsigned OFF = $clog2(LINE_BYTES);
  localparam int unsigned IW  = OFF + 1;
  localparam int unsigned PW  = idx_bits(NUM_LINE_PORTS);
  localparam int unsigned LW  = $clog2(RAM_RD_LAT + 1);

  state_t                    state_q;
  req_kind_t                 kind_q;
  logic [PW-1:0]             port_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [IW-1:0]             issue_idx;
  logic [OFF-1:0]            cap_idx;
  logic [LW-1:0]             cap_wait;
  logic [NUM_LINE_PORTS-1:0] line_ready_q;
  logic                      io_ready_q;
  logic [BYTE_WIDTH-1:0]     io_rdata_q;
  logic [BYTE_WIDTH-1:0]     rbuf [LINE_BYTES];

  logic [ADDR_WIDTH-1:0]     port_addr [NUM_LINE_PORTS];
  logic [BYTE_WIDTH-1:0]     wbyte [NUM_LINE_PORTS][LINE_BYTES];
  logic [NUM_LINE_PORTS-1:0] line_elig;
  logic                      io_req;
  logic [NUM_LINE_PORTS-1:0] grant_oh;
  logic [PW-1:0]             grant_idx;
  logic                      arb_advance;
  logic [ADDR_WIDTH-1:0]     grant_base;
  logic                      capturing;

  always_comb begin
    for (int unsigned p = 0; p < NUM_LINE_PORTS; p++) begin
      port_addr[p] = bus.line_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
        wbyte[p][k] = bus.line_wdata[(p*LINE_BYTES + k)*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LINE_BYTES; k++) begin
      bus.line_rdata[k*BYTE_WIDTH +: BYTE_WIDTH] = rbuf[k];
    end
  end

  assign bus.line_ready = line_ready_q;
  assign bus.io_ready   = io_ready_q;
  assign bus.io_rdata   = io_rdata_q;

  // A requester whose ready pulse is still high must not be re-granted on its stale valid.
  assign line_elig   = bus.line_valid & ~line_ready_q;
  assign io_req      = bus.io_valid & ~io_ready_q;
  assign arb_advance = (state_q == IDLE) && !io_req && (|grant_oh);
  assign grant_base  = port_addr[grant_idx] & ~ADDR_WIDTH'(LINE_BYTES - 1);

  // Read bytes are captured on the edges that follow, whether the controller is still issuing or is draining.
  assign capturing = (state_q == DRAIN) || ((state_q == ISSUE) && (kind_q == LINE_RD));

  rr_arbiter #(
    .N (NUM_LINE_PORTS)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (rdy),
    .req          (line_elig),
    .advance      (arb_advance),
    .grant_onehot (grant_oh),
    .grant_idx    (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      kind_q       <= LINE_RD;
      port_q       <= '0;
      base_q       <= '0;
      issue_idx    <= '0;
      cap_idx      <= '0;
      cap_wait     <= '0;
      line_ready_q <= '0;
      io_ready_q   <= 1'b0;
      io_rdata_q   <= '0;
      ram_rw       <= 1'b0;
      ram_addr     <= '0;
      ram_dout     <= '0;
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
        rbuf[k] <= '0;
      end
    end else if (rdy) begin
      line_ready_q <= '0;
      io_ready_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (io_req) begin
            if (!bus.io_rw) begin
              kind_q   <= IO_RD;
              ram_addr <= bus.io_addr;
              ram_rw   <= 1'b0;
              cap_idx  <= '0;
              cap_wait <= LW'(RAM_RD_LAT);
              state_q  <= DRAIN;
            end else if (!io_buffer_full) begin
              kind_q   <= IO_WR;
              ram_addr <= bus.io_addr;
              ram_dout <= bus.io_wdata;
              ram_rw   <= 1'b1;
              state_q  <= IOWR;
            end
          end else if (|grant_oh) begin
            port_q    <= grant_idx;
            kind_q    <= bus.line_rw[grant_idx] ? LINE_WR : LINE_RD;
            base_q    <= grant_base;
            ram_addr  <= grant_base;
            ram_rw    <= bus.line_rw[grant_idx];
            ram_dout  <= wbyte[grant_idx][0];
            issue_idx <= IW'(1);
            cap_idx   <= '0;
            cap_wait  <= LW'(RAM_RD_LAT);
            state_q   <= ISSUE;
          end
        end

        ISSUE: begin
          // A write spends one extra edge here after its last byte.
          // That is where ram_rw drops and the ready pulse starts.
          if (issue_idx == IW'(LINE_BYTES)) begin
            ram_rw               <= 1'b0;
            line_ready_q[port_q] <= 1'b1;
            state_q              <= IDLE;
          end else begin
            ram_addr <= base_q | ADDR_WIDTH'(issue_idx[OFF-1:0]);
            if (kind_q == LINE_WR) begin
              ram_dout <= wbyte[port_q][issue_idx[OFF-1:0]];
            end
            issue_idx <= issue_idx + 1'b1;
            if ((kind_q == LINE_RD) && (issue_idx == IW'(LINE_BYTES - 1))) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          ram_rw <= 1'b0;
        end

        IOWR: begin
          ram_rw     <= 1'b0;
          io_ready_q <= 1'b1;
          state_q    <= IDLE;
        end

        default: state_q <= IDLE;
      endcase

      if (capturing) begin
        if (cap_wait != LW'(1)) begin
          cap_wait <= cap_wait - 1'b1;
        end else if (kind_q == IO_RD) begin
          io_rdata_q <= ram_din;
          io_ready_q <= 1'b1;
          state_q    <= IDLE;
        end else begin
          rbuf[cap_idx] <= ram_din;
          cap_idx       <= cap_idx + 1'b1;
          if (cap_idx == OFF'(LINE_BYTES - 1)) begin
            line_ready_q[port_q] <= 1'b1;
            state_q              <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_mem_ctrler.sv
// Directed bench for line_mem_ctrler.
// DUT A uses the default parameters.
// DUT B uses LINE_BYTES=4 and RAM_RD_LAT=3.
// Each RAM model returns byte (addr[7:0] + 0x40), delayed to match the DUT's read latency.
module tb_line_mem_ctrler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return a[7:0] + 8'h40;
  endfunction

  // ---------------- DUT A: defaults ----------------
  logic        rst_n_a, rdy_a, full_a;
  logic [7:0]  ram_din_a, ram_dout_a;
  logic        ram_rw_a;
  logic [31:0] ram_addr_a, pa0;

  line_mem_ctrler_if #(.NUM_LINE_PORTS(2), .LINE_BYTES(16), .ADDR_WIDTH(32)) bus_a ();

  line_mem_ctrler #(
    .NUM_LINE_PORTS (2),
    .LINE_BYTES     (16),
    .ADDR_WIDTH     (32),
    .RAM_RD_LAT     (2)
  ) dut_a (
    .clk            (clk),
    .rst_n          (rst_n_a),
    .rdy            (rdy_a),
    .io_buffer_full (full_a),
    .ram_din        (ram_din_a),
    .ram_rw         (ram_rw_a),
    .ram_addr       (ram_addr_a),
    .ram_dout       (ram_dout_a),
    .bus            (bus_a)
  );

  // ---------------- DUT B: 4-byte lines, latency 3 ----------------
  logic        rst_n_b, rdy_b, full_b;
  logic [7:0]  ram_din_b, ram_dout_b;
  logic        ram_rw_b;
  logic [31:0] ram_addr_b, pb0, pb1;

  line_mem_ctrler_if #(.NUM_LINE_PORTS(2), .LINE_BYTES(4), .ADDR_WIDTH(32)) bus_b ();

  line_mem_ctrler #(
    .NUM_LINE_PORTS (2),
    .LINE_BYTES     (4),
    .ADDR_WIDTH     (32),
    .RAM_RD_LAT     (3)
  ) dut_b (
    .clk            (clk),
    .rst_n          (rst_n_b),
    .rdy            (rdy_b),
    .io_buffer_full (full_b),
    .ram_din        (ram_din_b),
    .ram_rw         (ram_rw_b),
    .ram_addr       (ram_addr_b),
    .ram_dout       (ram_dout_b),
    .bus            (bus_b)
  );

  // RAM read pipelines: latency 2 -> one stage, latency 3 -> two stages
  always_ff @(posedge clk) begin
    pa0 <= ram_addr_a;
    pb0 <= ram_addr_b;
    pb1 <= pb0;
  end
  assign ram_din_a = ram_byte(pa0);
  assign ram_din_b = ram_byte(pb1);

  task automatic wait_ready_a(output logic [1:0] seen);
    seen = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus_a.line_ready != 2'b00) begin
        seen = bus_a.line_ready;
        break;
      end
    end
  endtask

  initial begin
    logic [1:0]   seen;
    logic [1:0]   exp_order [4];
    logic [7:0]   exp_wr [4];
    logic [1:0]   ready_or;
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_wr    = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst_n_a = 1'b0; rdy_a = 1'b1; full_a = 1'b0;
    rst_n_b = 1'b0; rdy_b = 1'b1; full_b = 1'b0;
    bus_a.line_valid = '0; bus_a.line_rw = '0; bus_a.line_addr = '0; bus_a.line_wdata = '0;
    bus_a.io_valid = 1'b0; bus_a.io_rw = 1'b0; bus_a.io_addr = '0; bus_a.io_wdata = '0;
    bus_b.line_valid = '0; bus_b.line_rw = '0; bus_b.line_addr = '0; bus_b.line_wdata = '0;
    bus_b.io_valid = 1'b0; bus_b.io_rw = 1'b0; bus_b.io_addr = '0; bus_b.io_wdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_ram_addr", ram_addr_a, 32'h0);
    check_eq("rst_ram_rw", ram_rw_a, 1'b0);
    check_eq("rst_ram_dout", ram_dout_a, 8'h0);
    check_eq("rst_line_ready", bus_a.line_ready, 2'b00);
    check_eq("rst_line_rdata", bus_a.line_rdata, 128'h0);
    check_eq("rst_io_ready", bus_a.io_ready, 1'b0);
    check_eq("rst_io_rdata", bus_a.io_rdata, 8'h0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // ---- single line read, port 0, unaligned request address ----
    @(negedge clk);
    bus_a.line_addr  = {32'h0000_0000, 32'h0000_1005};
    bus_a.line_rw    = 2'b00;
    bus_a.line_valid = 2'b01;
    for (int j = 0; j <= 17; j++) begin
      @(negedge clk);
      check_eq($sformatf("rd_addr_%0d", j), ram_addr_a, 32'h1000 + ((j > 15) ? 15 : j));
      check_eq($sformatf("rd_rw_%0d", j), ram_rw_a, 1'b0);
      check_eq($sformatf("rd_ready_%0d", j), bus_a.line_ready, (j == 17) ? 2'b01 : 2'b00);
    end
    check_eq("rd_data", bus_a.line_rdata, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
    bus_a.line_valid = 2'b00;

    // ---- round robin after reset: port 0 first, then alternating ----
    @(negedge clk);
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    bus_a.line_addr  = {32'h0000_2030, 32'h0000_1000};
    bus_a.line_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_ready_a(seen);
      check_eq($sformatf("rr_grant_%0d", g), seen, exp_order[g]);
      if (g == 1) begin
        check_eq("rr_p1_data", bus_a.line_rdata, 128'h7F7E7D7C_7B7A7978_77767574_73727170);
      end
    end

    // ---- IO write stalled by full buffer blocks the pending line read ----
    bus_a.line_valid = 2'b01;
    bus_a.io_valid   = 1'b1;
    bus_a.io_rw      = 1'b1;
    bus_a.io_addr    = 32'h0003_0000;
    bus_a.io_wdata   = 8'h5C;
    full_a           = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check_eq($sformatf("stall_addr_%0d", j), ram_addr_a, 32'h0000_203F);
      check_eq($sformatf("stall_rw_%0d", j), ram_rw_a, 1'b0);
    end
    full_a = 1'b0;
    @(negedge clk);
    check_eq("iow_addr", ram_addr_a, 32'h0003_0000);
    check_eq("iow_rw", ram_rw_a, 1'b1);
    check_eq("iow_dout", ram_dout_a, 8'h5C);
    check_eq("iow_ready_early", bus_a.io_ready, 1'b0);
    @(negedge clk);
    check_eq("iow_ready", bus_a.io_ready, 1'b1);
    check_eq("iow_rw_drop", ram_rw_a, 1'b0);
    bus_a.io_valid = 1'b0;
    @(negedge clk);
    check_eq("after_io_line_addr", ram_addr_a, 32'h0000_1000);
    check_eq("after_io_io_ready", bus_a.io_ready, 1'b0);
    wait_ready_a(seen);
    check_eq("after_io_line_ready", seen, 2'b01);
    bus_a.line_valid = 2'b00;

    // ---- rdy held low mid-issue, then reset mid-transaction ----
    @(negedge clk);
    bus_a.line_valid = 2'b01;
    repeat (3) @(negedge clk);
    check_eq("frz_start_addr", ram_addr_a, 32'h0000_1002);
    rdy_a = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_eq($sformatf("frz_addr_%0d", j), ram_addr_a, 32'h0000_1002);
    end
    rst_n_a = 1'b0;
    #1;
    check_eq("abort_addr", ram_addr_a, 32'h0);
    check_eq("abort_rdata", bus_a.line_rdata, 128'h0);
    check_eq("abort_rw", ram_rw_a, 1'b0);
    bus_a.line_valid = 2'b00;
    rdy_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    ready_or = '0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      ready_or = ready_or | bus_a.line_ready;
    end
    check_eq("abort_no_ready", ready_or, 2'b00);

    // ---- DUT B: 4-byte line write ----
    @(negedge clk);
    bus_b.line_addr  = {32'h0, 32'h0000_2000};
    bus_b.line_wdata = 64'h0000_0000_DDCC_BBAA;
    bus_b.line_rw    = 2'b01;
    bus_b.line_valid = 2'b01;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      check_eq($sformatf("wr_addr_%0d", j), ram_addr_b, 32'h2000 + ((j > 3) ? 3 : j));
      check_eq($sformatf("wr_rw_%0d", j), ram_rw_b, (j < 4) ? 1'b1 : 1'b0);
      check_eq($sformatf("wr_ready_%0d", j), bus_b.line_ready, (j == 4) ? 2'b01 : 2'b00);
      if (j < 4) check_eq($sformatf("wr_dout_%0d", j), ram_dout_b, exp_wr[j]);
    end
    bus_b.line_valid = 2'b00;

    // ---- DUT B: IO read with latency 3 ----
    @(negedge clk);
    bus_b.io_valid = 1'b1;
    bus_b.io_rw    = 1'b0;
    bus_b.io_addr  = 32'h0000_05A5;
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      check_eq($sformatf("ior_addr_%0d", j), ram_addr_b, 32'h0000_05A5);
      check_eq($sformatf("ior_ready_%0d", j), bus_b.io_ready, (j == 3) ? 1'b1 : 1'b0);
    end
    check_eq("ior_data", bus_b.io_rdata, 8'hE5);
    bus_b.io_valid = 1'b0;
    @(negedge clk);
    check_eq("ior_ready_drop", bus_b.io_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_mem_ctrler.md
# line_mem_ctrler

Parametrised successor to the two-client memory controller. It serialises line fills, line write-backs and single-byte IO accesses onto the byte-wide RAM port for `NUM_LINE_PORTS` cache clients plus one IO channel. Line clients are arbitrated round-robin, and the IO channel has strict priority. Line size and RAM read latency are parameters. It sits between the icache/dcache instances (and IO unit) and the top-level RAM.

## Interface
- `NUM_LINE_PORTS`, 2, number of line clients (≥1); port 0 is conventionally the icache.
- `LINE_BYTES`, 16, bytes per line, power of two, 4..64.
- `ADDR_WIDTH`, 32, byte address width.
- `RAM_RD_LAT`, 2, clock edges from a RAM address being registered to its read byte being sampled (≥1).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; when low, all registers hold.
- `io_buffer_full` in 1: IO write sink cannot accept a byte.
- `ram_din` in 8: RAM read data.
- `ram_rw` out 1: 1 = write.
- `ram_addr` out `ADDR_WIDTH`.
- `ram_dout` out 8: RAM write data.
- `line_valid` in `NUM_LINE_PORTS`: per-client request.
- `line_rw` in `NUM_LINE_PORTS`: 1 = write-back.
- `line_addr` in `NUM_LINE_PORTS*ADDR_WIDTH`: flattened; the low log2(`LINE_BYTES`) bits are ignored.
- `line_wdata` in `NUM_LINE_PORTS*LINE_BYTES*8`: flattened; byte k = bits [8k+7:8k].
- `line_ready` out `NUM_LINE_PORTS`: one-cycle completion pulse, one-hot.
- `line_rdata` out `LINE_BYTES*8`: shared fill data, valid while `line_ready` is high.
- `io_valid`, `io_rw` in 1: IO request and direction.
- `io_addr` in `ADDR_WIDTH`.
- `io_wdata` in 8.
- `io_ready` out 1: one-cycle completion pulse.
- `io_rdata` out 8.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, IOWR.
- **IDLE.** Grant is evaluated each enabled edge.
  - If `io_valid` is high, IO wins.
  - An IO write is granted only if `io_buffer_full` is low. While an IO write is stalled, no line client is granted, which preserves ordering.
  - Otherwise the round-robin arbiter picks among eligible `line_valid` bits. The search starts at the port after the last granted one.
  - A port whose ready pulse is high this cycle is ineligible, so a still-high valid cannot cause a duplicate grant.
- **Line grant** (edge E0):
  - Latch port index, direction and base address (low bits zeroed).
  - Drive `ram_addr` = base+0, `ram_rw` = `line_rw`, `ram_dout` = byte 0.
  - Go to ISSUE with byte index = 1.
- **ISSUE:** each edge drives base+idx (and byte idx for writes), then idx increments. After byte `LINE_BYTES`-1 has been issued:
  - writes return to IDLE;
  - reads go to DRAIN.
- **Read capture:** the byte addressed at edge E0+k is sampled into `line_rdata` byte k at edge E0+k+`RAM_RD_LAT`. A capture counter runs independently of the issue counter.
- **DRAIN:** `ram_rw` = 0 and the address is held. Exit to IDLE on the edge that captures the last byte.
- **IO read:** at E0 drive `io_addr`, `ram_rw` = 0. Go through DRAIN with a 1-byte length. `io_rdata` is captured at E0+`RAM_RD_LAT`.
- **IO write:** at E0 drive `io_addr`, `io_wdata`, `ram_rw` = 1, then go to IOWR. At E0+1: `ram_rw` = 0, `io_ready` = 1, go to IDLE.
- `ram_rw` is 0 in every cycle not belonging to a write, and is never left high in IDLE.
- No transaction overlaps another. A new grant can occur at the earliest on the edge after a transaction ends.
- Requesters hold valid, rw, addr and wdata stable from request until their ready pulse. They must drop valid, or change the request, in the cycle after ready.

## Timing
- Reset: all outputs 0, state IDLE, round-robin pointer = `NUM_LINE_PORTS`-1 (so port 0 is first), counters 0. Reset mid-transaction aborts it with no ready pulse.
- Line read: `line_ready` rises at edge E0+`LINE_BYTES`-1+`RAM_RD_LAT`. With defaults that is 17 edges after grant.
- Line write: `line_ready` rises at edge E0+`LINE_BYTES`, the same edge on which `ram_rw` drops.
- IO read: `io_ready` at E0+`RAM_RD_LAT`. IO write: `io_ready` at E0+1.
- Grant occurs on the first enabled edge with a qualifying request; the request-to-grant latency is 0 cycles when idle.
- `rdy` low: every register holds, including ready pulses, which therefore stretch until `rdy` returns.
- Address arithmetic is base | idx with no carry; lines never cross alignment.

## Structure
- Shared package `mem_ctrl_pkg`:
  - FSM state encoding;
  - requester-kind encoding (LINE_RD, LINE_WR, IO_RD, IO_WR);
  - `BYTE_WIDTH` = 8.
- One sub-module `rr_arbiter`, parameterised by N:
  - inputs `req[N-1:0]`, `advance`;
  - outputs `grant_onehot`, `grant_idx`;
  - the pointer updates only on `advance`.

## Test plan
- Single read, defaults: port 0 reads 0x1000, RAM byte k = k+0x40. Expect addresses 0x1000..0x100F on consecutive edges, `line_rdata` = 0x4F..0x40 (MSB first), and `line_ready[0]` at E0+17.
- Round-robin: ports 0 and 1 hold valid continuously for reads. Expect grants 0,1,0,1 and never the same port twice in a row.
- IO priority and stall: with a line read pending, assert `io_valid` write 0x30000 with `io_buffer_full` = 1 for 5 cycles. Expect no grant during those cycles. After full drops, expect an IO write with `io_ready` one edge later, then the line grant.
- Line write, `LINE_BYTES` = 4: `line_wdata` = 0xDDCCBBAA to 0x2000. Expect 0xAA..0xDD written with `ram_rw` = 1 for exactly 4 cycles, then `line_ready` and `ram_rw` = 0 on the same edge.
- `RAM_RD_LAT` = 3, IO read: expect `io_rdata` sampled and `io_ready` 3 edges after grant.
- Hold `rdy` low mid-ISSUE for 4 cycles, then assert `rst_n` low mid-transaction. Expect a frozen address/index while `rdy` is low, then immediate zeroing of all outputs with no ready pulse.
